// File: rtl/pp_pipeline_accel_axi2mat_row_reader.sv
// AXI4 read master that fetches a rows x cols frame from DDR and streams it out row by row.
// Build option: define PP_AXI2MAT_RRESP_CHECK_EN to flag non-OKAY read responses on err.
//
// state | meaning
// IDLE  | waiting for ap_start; frame parameters latched on start
// CALC  | derive byte pitch and beats per row from latched parameters
// ISSUE | issuing AR bursts, each confined to one row
// DRAIN | all ARs accepted; waiting for the last beat to leave downstream
// DONE  | ap_done high until ap_continue
module pp_pipeline_accel_axi2mat_row_reader #(
    parameter int DATA_W          = 64,
    parameter int PIX_BYTES       = 1,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    input  logic              ap_continue,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [63:0]       base_addr,
    input  logic [15:0]       rows,
    input  logic [15:0]       cols,
    input  logic [31:0]       stride,
    output logic [63:0]       m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [DATA_W-1:0] out_tdata,
    output logic              out_tlast,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic              err
);
    localparam int BPB = DATA_W / 8;
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [16:0]   BURST_MAX = 17'(MAX_BURST);
    localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [15:0]       rows_q, rows_d, cols_q, cols_d;
    logic [31:0]       stride_q, stride_d, pitch_q, pitch_d;
    logic [16:0]       bpr_q, bpr_d, beat_q, beat_d, r_beat_q, r_beat_d;
    logic [63:0]       row_addr_q, row_addr_d, araddr_q, araddr_d;
    logic [15:0]       ar_row_q, ar_row_d, acc_rows_q, acc_rows_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic              arvalid_q, arvalid_d, ready_q, ready_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tlast_q, tlast_d, tvalid_q, tvalid_d, err_q, err_d;

    logic        ar_hs, r_hs, o_hs, r_end;
    logic [31:0] row_bytes;
    logic [15:0] pitch_px;
    logic [16:0] remain, burst, beat_next;

    assign m_axi_rready = ~tvalid_q | out_tready;
    assign ar_hs        = arvalid_q & m_axi_arready;
    assign r_hs         = m_axi_rvalid & m_axi_rready;
    assign r_end        = r_hs & m_axi_rlast;
    assign o_hs         = tvalid_q & out_tready;

    assign row_bytes = 32'(cols_q) * 32'(PIX_BYTES);
    assign pitch_px  = (stride_q == 32'hFFFF_FFFF) ? cols_q : stride_q[15:0];
    assign remain    = bpr_q - beat_q;
    assign burst     = (remain > BURST_MAX) ? BURST_MAX : remain;
    assign beat_next = beat_q + 17'(arlen_q) + 17'd1;

    always_comb begin
        state_d    = state_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        stride_d   = stride_q;
        pitch_d    = pitch_q;
        bpr_d      = bpr_q;
        beat_d     = beat_q;
        r_beat_d   = r_beat_q;
        row_addr_d = row_addr_q;
        araddr_d   = araddr_q;
        ar_row_d   = ar_row_q;
        acc_rows_d = acc_rows_q;
        outst_d    = outst_q;
        arvalid_d  = arvalid_q;
        arlen_d    = arlen_q;
        ready_d    = 1'b0;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        tvalid_d   = tvalid_q;
        err_d      = err_q;

        if (ar_hs && !r_end)      outst_d = outst_q + 1'b1;
        else if (!ar_hs && r_end) outst_d = outst_q - 1'b1;

        // Row position on the R side is counted independently of rlast.
        if (r_hs) begin
            tdata_d  = m_axi_rdata;
            tvalid_d = 1'b1;
            tlast_d  = (r_beat_q == bpr_q - 17'd1);
            r_beat_d = (r_beat_q == bpr_q - 17'd1) ? 17'd0 : r_beat_q + 17'd1;
        end else if (out_tready) begin
            tvalid_d = 1'b0;
        end
        if (o_hs && tlast_q) acc_rows_d = acc_rows_q + 16'd1;

`ifdef PP_AXI2MAT_RRESP_CHECK_EN
        if (r_hs && m_axi_rresp != 2'b00) err_d = 1'b1;
`endif

        case (state_q)
            S_IDLE: if (ap_start) begin
                rows_d     = rows;
                cols_d     = cols;
                stride_d   = stride;
                row_addr_d = base_addr;
                ready_d    = 1'b1;
                err_d      = 1'b0;
                state_d    = S_CALC;
            end
            S_CALC: begin
                pitch_d    = 32'(pitch_px) * 32'(PIX_BYTES);
                bpr_d      = 17'((row_bytes + 32'(BPB - 1)) / 32'(BPB));
                beat_d     = 17'd0;
                r_beat_d   = 17'd0;
                ar_row_d   = 16'd0;
                acc_rows_d = 16'd0;
                state_d    = (rows_q == 16'd0 || cols_q == 16'd0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    if (beat_next == bpr_q) begin
                        beat_d     = 17'd0;
                        row_addr_d = row_addr_q + {32'd0, pitch_q};
                        ar_row_d   = ar_row_q + 16'd1;
                        if (ar_row_q == rows_q - 16'd1) state_d = S_DRAIN;
                    end else begin
                        beat_d = beat_next;
                    end
                end else if (!arvalid_q && outst_q < OUTST_MAX) begin
                    arvalid_d = 1'b1;
                    araddr_d  = row_addr_q + 64'(beat_q) * 64'(BPB);
                    arlen_d   = 8'(burst - 17'd1);
                end
            end
            S_DRAIN: if (acc_rows_q == rows_q && outst_q == '0) state_d = S_DONE;
            S_DONE:  if (ap_continue) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= S_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            stride_q   <= '0;
            pitch_q    <= '0;
            bpr_q      <= '0;
            beat_q     <= '0;
            r_beat_q   <= '0;
            row_addr_q <= '0;
            araddr_q   <= '0;
            ar_row_q   <= '0;
            acc_rows_q <= '0;
            outst_q    <= '0;
            arvalid_q  <= 1'b0;
            arlen_q    <= '0;
            ready_q    <= 1'b0;
            tdata_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            stride_q   <= stride_d;
            pitch_q    <= pitch_d;
            bpr_q      <= bpr_d;
            beat_q     <= beat_d;
            r_beat_q   <= r_beat_d;
            row_addr_q <= row_addr_d;
            araddr_q   <= araddr_d;
            ar_row_q   <= ar_row_d;
            acc_rows_q <= acc_rows_d;
            outst_q    <= outst_d;
            arvalid_q  <= arvalid_d;
            arlen_q    <= arlen_d;
            ready_q    <= ready_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
            err_q      <= err_d;
        end
    end

`ifndef PP_AXI2MAT_RRESP_CHECK_EN
    logic unused_rresp;
    assign unused_rresp = ^m_axi_rresp;
`endif

    // Held low during reset so a host never sees idle before the block is out of reset.
    assign ap_idle       = ap_rst_n & (state_q == S_IDLE) & ~ap_start;
    assign ap_done       = (state_q == S_DONE);
    assign ap_ready      = ready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arvalid = arvalid_q;
    assign out_tdata     = tdata_q;
    assign out_tlast     = tlast_q;
    assign out_tvalid    = tvalid_q;
    assign err           = err_q;
endmodule

// File: tb/tb_pp_pipeline_accel_axi2mat_row_reader.sv
// Bench for the AXI-to-stream row reader: directed frame table, outstanding-limit sequence,
// and random frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_pp_pipeline_accel_axi2mat_row_reader;
    localparam int DW   = 64;
    localparam int BPB  = DW / 8;
    localparam int PIX  = 1;
    localparam int MAXB = 16;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n, ap_start, ap_done, ap_continue, ap_idle, ap_ready;
    logic [63:0]   base_addr;
    logic [15:0]   rows, cols;
    logic [31:0]   stride;
    logic [63:0]   m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic          m_axi_arvalid, m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [DW-1:0] out_tdata;
    logic          out_tlast, out_tvalid, out_tready, err;

    always #5 ap_clk = ~ap_clk;

    pp_pipeline_accel_axi2mat_row_reader #(
        .DATA_W(DW), .PIX_BYTES(PIX), .MAX_BURST(MAXB), .MAX_OUTSTANDING(4)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
        .ap_continue(ap_continue), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .base_addr(base_addr), .rows(rows), .cols(cols), .stride(stride),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .out_tdata(out_tdata), .out_tlast(out_tlast), .out_tvalid(out_tvalid),
        .out_tready(out_tready), .err(err)
    );

    typedef struct { logic [63:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [63:0] data; logic last; } beat_t;
    typedef struct {
        logic [63:0] base; logic [15:0] nr; logic [15:0] nc; logic [31:0] st; int inj;
        int n_ar; int n_beats; int n_last;
        logic [63:0] a0; logic [7:0] l0; logic [63:0] an; logic [7:0] ln;
    } vec_t;

    ar_t   ar_log[$], exp_ar[$], pend[$];
    beat_t out_log[$], exp_beats[$];

    int total = 0;
    int bad = 0;
    int ar_rate = 100, r_rate = 100, o_rate = 100;
    bit r_hold = 0;
    int inject_idx = -1;
    int r_count = 0;
    int rb = 0;

    function automatic logic [63:0] memf(input logic [63:0] a);
        return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0F1E_2D3C_4B5A_6978;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Frame-level model: every row is cut into MAX_BURST-beat pieces from its own start address.
    task automatic build_model(input logic [63:0] base, input logic [15:0] nr,
                               input logic [15:0] nc, input logic [31:0] st);
        logic [63:0] bpr, pitch, row, b, len, i;
        exp_ar.delete();
        exp_beats.delete();
        bpr   = (64'(nc) * 64'(PIX) + 64'(BPB - 1)) / 64'(BPB);
        pitch = ((st == 32'hFFFF_FFFF) ? 64'(nc) : 64'(st[15:0])) * 64'(PIX);
        for (int r = 0; r < int'(nr); r++) begin
            row = base + 64'(r) * pitch;
            b = 0;
            while (b < bpr) begin
                len = (bpr - b > 64'(MAXB)) ? 64'(MAXB) : bpr - b;
                exp_ar.push_back(ar_t'{row + b * 64'(BPB), 8'(len - 64'd1)});
                i = 0;
                while (i < len) begin
                    exp_beats.push_back(beat_t'{memf(row + (b + i) * 64'(BPB)), (b + i == bpr - 64'd1)});
                    i = i + 1;
                end
                b = b + len;
            end
        end
    endtask

    // AXI slave and stream sink: sample at negedge, act just after the following posedge.
    initial begin : slave
        bit ar_hs, r_hs, o_hs;
        ar_t ar_s;
        beat_t o_s;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        out_tready    = 1'b0;
        forever begin
            @(negedge ap_clk);
            ar_hs = m_axi_arvalid && m_axi_arready;
            ar_s  = '{m_axi_araddr, m_axi_arlen};
            r_hs  = m_axi_rvalid && m_axi_rready;
            o_hs  = out_tvalid && out_tready;
            o_s   = '{out_tdata, out_tlast};
            @(posedge ap_clk);
            #1;
            if (ar_hs) begin
                ar_log.push_back(ar_s);
                pend.push_back(ar_s);
            end
            if (o_hs) out_log.push_back(o_s);
            if (r_hs && pend.size() > 0) begin
                r_count++;
                if (rb == int'(pend[0].len)) begin
                    void'(pend.pop_front());
                    rb = 0;
                end else begin
                    rb++;
                end
            end
            if (!(m_axi_rvalid && !r_hs)) begin
                if (pend.size() > 0 && !r_hold && int'($urandom_range(99)) < r_rate) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = memf(pend[0].addr + 64'(rb) * 64'(BPB));
                    m_axi_rlast  = (rb == int'(pend[0].len));
                    m_axi_rresp  = (r_count == inject_idx) ? 2'b10 : 2'b00;
                end else begin
                    m_axi_rvalid = 1'b0;
                    m_axi_rlast  = 1'b0;
                    m_axi_rresp  = 2'b00;
                end
            end
            m_axi_arready = (int'($urandom_range(99)) < ar_rate);
            out_tready    = (int'($urandom_range(99)) < o_rate);
        end
    end

    task automatic run_frame(input string tag, input logic [63:0] base, input logic [15:0] nr,
                             input logic [15:0] nc, input logic [31:0] st, input int inj,
                             input int hold);
        int cyc_r, cyc_d;
        bit seen;
        bit exp_err;
        build_model(base, nr, nc, st);
        ar_log.delete();
        out_log.delete();
        r_count    = 0;
        inject_idx = inj;
        r_hold     = (hold > 0);
        base_addr  = base;
        rows       = nr;
        cols       = nc;
        stride     = st;
        ap_start   = 1'b1;
        seen = 0;
        cyc_r = 0;
        while (!seen && cyc_r < 10) begin
            @(negedge ap_clk);
            cyc_r++;
            if (ap_ready) seen = 1;
        end
        ap_start = 1'b0;
        chk({tag, " ap_ready"}, 64'(seen), 64'd1);
        chk({tag, " err cleared"}, 64'(err), 64'd0);
        if (hold > 0) begin
            repeat (hold) @(negedge ap_clk);
            chk({tag, " ar cap"}, 64'(ar_log.size()), 64'((exp_ar.size() < 4) ? exp_ar.size() : 4));
            chk({tag, " arvalid parked"}, 64'(m_axi_arvalid), 64'd0);
            r_hold = 0;
        end
        seen = 0;
        cyc_d = 0;
        while (!seen && cyc_d < 6000) begin
            @(negedge ap_clk);
            cyc_d++;
            if (ap_done) seen = 1;
        end
        chk({tag, " ap_done"}, 64'(seen), 64'd1);
        if (nr == 16'd0 || nc == 16'd0)
            chk({tag, " empty done latency"}, 64'(cyc_r + cyc_d <= 3), 64'd1);
        repeat (3) @(negedge ap_clk);
        chk({tag, " done held"}, 64'(ap_done), 64'd1);
        ap_continue = 1'b1;
        @(negedge ap_clk);
        ap_continue = 1'b0;
        chk({tag, " done cleared"}, 64'(ap_done), 64'd0);
        chk({tag, " idle"}, 64'(ap_idle), 64'd1);
`ifdef PP_AXI2MAT_RRESP_CHECK_EN
        exp_err = (inj >= 0 && inj < exp_beats.size());
`else
        exp_err = 1'b0;
`endif
        chk({tag, " err"}, 64'(err), 64'(exp_err));
        chk({tag, " ar count"}, 64'(ar_log.size()), 64'(exp_ar.size()));
        for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++) begin
            chk($sformatf("%s ar%0d addr", tag, i), ar_log[i].addr, exp_ar[i].addr);
            chk($sformatf("%s ar%0d len", tag, i), 64'(ar_log[i].len), 64'(exp_ar[i].len));
        end
        chk({tag, " beat count"}, 64'(out_log.size()), 64'(exp_beats.size()));
        for (int i = 0; i < exp_beats.size() && i < out_log.size(); i++) begin
            chk($sformatf("%s beat%0d data", tag, i), out_log[i].data, exp_beats[i].data);
            chk($sformatf("%s beat%0d last", tag, i), 64'(out_log[i].last), 64'(exp_beats[i].last));
        end
    endtask

    initial begin : main
        vec_t vt[8];
        int nl;
        logic [15:0] rnr, rnc;
        logic [31:0] rst_v;
        vt[0] = '{64'h1000, 16'd2, 16'd16, 32'hFFFF_FFFF, 2, 2, 4, 2, 64'h1000, 8'd1, 64'h1010, 8'd1};
        vt[1] = '{64'h0, 16'd1, 16'd320, 32'hFFFF_FFFF, -1, 3, 40, 1, 64'h0, 8'd15, 64'h100, 8'd7};
        vt[2] = '{64'h0, 16'd3, 16'd8, 32'd64, -1, 3, 3, 3, 64'h0, 8'd0, 64'h80, 8'd0};
        vt[3] = '{64'h3000, 16'd0, 16'd16, 32'hFFFF_FFFF, -1, 0, 0, 0, 64'h0, 8'd0, 64'h0, 8'd0};
        vt[4] = '{64'h3000, 16'd5, 16'd0, 32'hFFFF_FFFF, -1, 0, 0, 0, 64'h0, 8'd0, 64'h0, 8'd0};
        vt[5] = '{64'h2000, 16'd2, 16'd20, 32'd100, -1, 2, 6, 2, 64'h2000, 8'd2, 64'h2064, 8'd2};
        vt[6] = '{64'hFFFF_FFFF_FFFF_FFC0, 16'd3, 16'd64, 32'd64, -1, 3, 24, 3,
                  64'hFFFF_FFFF_FFFF_FFC0, 8'd7, 64'h40, 8'd7};
        vt[7] = '{64'h80, 16'd1, 16'd17, 32'hFFFF_FFFF, -1, 1, 3, 1, 64'h80, 8'd2, 64'h80, 8'd2};

        ap_rst_n    = 1'b0;
        ap_start    = 1'b0;
        ap_continue = 1'b0;
        base_addr   = '0;
        rows        = '0;
        cols        = '0;
        stride      = '0;
        repeat (3) @(negedge ap_clk);
        chk("rst ap_done", 64'(ap_done), 64'd0);
        chk("rst ap_ready", 64'(ap_ready), 64'd0);
        chk("rst ap_idle", 64'(ap_idle), 64'd0);
        chk("rst arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("rst araddr", m_axi_araddr, 64'd0);
        chk("rst arlen", 64'(m_axi_arlen), 64'd0);
        chk("rst tvalid", 64'(out_tvalid), 64'd0);
        chk("rst tdata", out_tdata, 64'd0);
        chk("rst tlast", 64'(out_tlast), 64'd0);
        chk("rst err", 64'(err), 64'd0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("post-rst idle", 64'(ap_idle), 64'd1);

        ar_rate = 60; r_rate = 70; o_rate = 50;
        for (int v = 0; v < 8; v++) begin
            run_frame($sformatf("vec%0d", v), vt[v].base, vt[v].nr, vt[v].nc, vt[v].st, vt[v].inj, 0);
            chk($sformatf("vec%0d hand n_ar", v), 64'(ar_log.size()), 64'(vt[v].n_ar));
            chk($sformatf("vec%0d hand n_beats", v), 64'(out_log.size()), 64'(vt[v].n_beats));
            nl = 0;
            foreach (out_log[k]) if (out_log[k].last) nl++;
            chk($sformatf("vec%0d hand n_tlast", v), 64'(nl), 64'(vt[v].n_last));
            if (vt[v].n_ar > 0 && ar_log.size() > 0) begin
                chk($sformatf("vec%0d hand first addr", v), ar_log[0].addr, vt[v].a0);
                chk($sformatf("vec%0d hand first len", v), 64'(ar_log[0].len), 64'(vt[v].l0));
                chk($sformatf("vec%0d hand last addr", v), ar_log[ar_log.size()-1].addr, vt[v].an);
                chk($sformatf("vec%0d hand last len", v), 64'(ar_log[ar_log.size()-1].len), 64'(vt[v].ln));
            end
        end

        // R channel starved with arready high: AR issue must stop at the outstanding limit.
        ar_rate = 100; r_rate = 100; o_rate = 50;
        run_frame("hold", 64'h8000, 16'd6, 16'd128, 32'hFFFF_FFFF, -1, 30);

        for (int n = 0; n < 12; n++) begin
            ar_rate = int'($urandom_range(30, 100));
            r_rate  = int'($urandom_range(30, 100));
            o_rate  = int'($urandom_range(30, 100));
            rnr     = 16'($urandom_range(1, 4));
            rnc     = 16'($urandom_range(1, 200));
            rst_v   = ($urandom_range(1) == 0) ? 32'hFFFF_FFFF : 32'(rnc) + 32'($urandom_range(0, 40));
            run_frame($sformatf("rnd%0d", n), {$urandom, $urandom} & ~64'h7, rnr, rnc, rst_v,
                      ($urandom_range(2) == 0) ? int'($urandom_range(0, 20)) : -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
